// File: rtl/ram32_arb_pkg.sv
// Shared widths and FSM encoding for the two-client RAM sequencer.
package ram32_arb_pkg;

  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram32_rr_pick.sv
// Two-way round-robin picker: on a tie the port not served last wins.
module ram32_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    pick  = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/ram32_arbiter.sv
// Sequencer/arbiter owning the single-port RAM: one access per grant,
// followed by an ack/turnaround cycle, round-robin between two clients.
module ram32_arbiter
  import ram32_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wre,
  inout  wire  [DATA_W-1:0] ram_data
);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              load;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              pick_req0, pick_req1, pick_valid, pick_port;

  // The port being acked still holds req in RESP; mask it so only the other can win.
  assign pick_req0 = req0 & ~((state_q == RESP) & ~gnt_q);
  assign pick_req1 = req1 & ~((state_q == RESP) &  gnt_q);

  ram32_rr_pick u_pick (
    .req0  (pick_req0),
    .req1  (pick_req1),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (pick_valid) begin
          state_d = ACCESS;
          gnt_d   = pick_port;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        last_d  = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (load) begin
        addr_q <= pick_port ? addr1 : addr0;
        we_q   <= pick_port ? we1   : we0;
      end
      if ((state_q == ACCESS) && !we_q) begin
        if (gnt_q) rdata1_q <= ram_data;
        else       rdata0_q <= ram_data;
      end
    end
  end

  // Write data only matters while ACCESS && we_q, both of which are reset.
  always_ff @(posedge clk) begin
    if (load) wdata_q <= pick_port ? wdata1 : wdata0;
  end

  always_comb begin
    ram_wre = (state_q == ACCESS) & we_q;
    ack0    = (state_q == RESP) & ~gnt_q;
    ack1    = (state_q == RESP) &  gnt_q;
  end

  assign ram_addr = addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_data = ram_wre ? wdata_q : 'z;

endmodule

// File: tb/tb_ram32_arbiter.sv
// Bench for ram32_arbiter with a behavioural 128x32 RAM on the shared bus.
module tb_ram32_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addr;
  logic          ram_wre;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem [128];
  logic          mem_clr;
  logic          ram_oe;

  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] ref_rd [2];
  int            ref_last;

  int   nvec  = 0;
  int   nfail = 0;
  logic prev_wre = 1'b0;
  logic wre_viol = 1'b0;

  typedef struct {
    bit          p;
    bit          we;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  ram32_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .ram_addr (ram_addr),
    .ram_wre  (ram_wre),
    .ram_data (ram_data)
  );

  // RAM: combinational read; with ram_oe low it drives zero so a stray DUT drive shows up.
  assign ram_data = ram_wre ? 'z : (ram_oe ? mem[ram_addr] : '0);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (ram_wre) begin
      mem[ram_addr] <= ram_data;
    end
  end

  always @(negedge clk) begin
    if (ram_wre && prev_wre) wre_viol <= 1'b1;
    prev_wre <= ram_wre;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 7'h7F;
    return 7'($urandom_range(0, 7));
  endfunction

  // One transaction per requesting port, both raised together from IDLE.
  task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [6:0] a0, input logic [6:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit probe, input bit perturb);
    bit          want [2];
    bit          ww [2];
    logic [6:0]  aa [2];
    logic [31:0] dd [2];
    int          n_exp [2];
    logic [31:0] rd_exp [2];
    int          first, second, p;
    want[0] = r0; want[1] = r1;
    ww[0] = w0;   ww[1] = w1;
    aa[0] = a0;   aa[1] = a1;
    dd[0] = d0;   dd[1] = d1;
    rd_exp[0] = ref_rd[0];
    rd_exp[1] = ref_rd[1];
    first  = (r0 && r1) ? ((ref_last == 1) ? 0 : 1) : (r1 ? 1 : 0);
    second = 1 - first;
    n_exp[first]  = 2;
    n_exp[second] = 4;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : second;
      if (want[p]) begin
        if (ww[p]) ref_mem[aa[p]] = dd[p];
        else       ref_rd[p] = ref_mem[aa[p]];
        rd_exp[p] = ref_rd[p];
        ref_last  = p;
      end
    end
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (n == 1 || n == 3) begin
        p = (n == 1) ? first : second;
        if (want[p]) begin
          chk("access_addr", 32'(ram_addr), 32'(aa[p]));
          chk("access_wre", 32'(ram_wre), 32'(ww[p]));
          if (ww[p]) chk("access_wdata", ram_data, dd[p]);
        end
        if (n == 1 && perturb) begin
          if (first == 0) begin addr0 = ~addr0; wdata0 = ~wdata0; we0 = ~we0; end
          else            begin addr1 = ~addr1; wdata1 = ~wdata1; we1 = ~we1; end
        end
      end
      chk("ack0", 32'(ack0), 32'(want[0] && n == n_exp[0]));
      chk("ack1", 32'(ack1), 32'(want[1] && n == n_exp[1]));
      for (int q = 0; q < 2; q++) begin
        if (want[q] && n == n_exp[q]) begin
          chk($sformatf("rdata%0d", q), (q == 1) ? rdata1 : rdata0, rd_exp[q]);
          if (q == 0) req0 = 1'b0;
          else        req1 = 1'b0;
        end
      end
      if (probe && n == 2 && want[second]) begin
        ram_oe = 1'b0;
        #1;
        chk("resp_bus_released", ram_data, 32'h0);
        chk("resp_wre", 32'(ram_wre), 32'h0);
        ram_oe = 1'b1;
      end
    end
  endtask

  // Requests held continuously for nacc reads; checks ack schedule and order.
  task automatic hold(input bit h0, input bit h1, input int nacc);
    int first, per, t_last, k, pk;
    bit e0, e1, hit;
    addr0 = 7'h7F; addr1 = 7'h01; we0 = 1'b0; we1 = 1'b0;
    first  = (h0 && h1) ? ((ref_last == 1) ? 0 : 1) : (h1 ? 1 : 0);
    per    = (h0 && h1) ? 2 : 3;
    t_last = 2 + per * (nacc - 1);
    k = 0;
    req0 = h0; req1 = h1;
    for (int n = 1; n <= t_last; n++) begin
      @(posedge clk); #1;
      pk  = (h0 && h1) ? (first ^ (k & 1)) : first;
      hit = (n == 2 + per * k);
      e0  = hit && (pk == 0);
      e1  = hit && (pk == 1);
      chk("hold_ack0", 32'(ack0), 32'(e0));
      chk("hold_ack1", 32'(ack1), 32'(e1));
      if (hit) begin
        ref_rd[pk] = ref_mem[(pk == 1) ? 7'h01 : 7'h7F];
        ref_last   = pk;
        chk("hold_rdata", (pk == 1) ? rdata1 : rdata0, ref_rd[pk]);
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 7'h00, 32'hBBBBBBBB, 32'h00000000};
    tbl[1] = '{1'b0, 1'b0, 7'h00, 32'h0,        32'hBBBBBBBB};
    tbl[2] = '{1'b1, 1'b1, 7'h7F, 32'h12345678, 32'h00000000};
    tbl[3] = '{1'b1, 1'b0, 7'h7F, 32'h0,        32'h12345678};
    tbl[4] = '{1'b0, 1'b0, 7'h7F, 32'h0,        32'h12345678};
    tbl[5] = '{1'b1, 1'b1, 7'h40, 32'h5A5A5A5A, 32'h12345678};
    tbl[6] = '{1'b1, 1'b0, 7'h00, 32'h0,        32'hBBBBBBBB};
    tbl[7] = '{1'b0, 1'b1, 7'h01, 32'h0F0F0F0F, 32'h12345678};
    tbl[8] = '{1'b0, 1'b0, 7'h40, 32'h0,        32'h5A5A5A5A};

    rst_n = 1'b0; mem_clr = 1'b1; ram_oe = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack0", 32'(ack0), 32'h0);
    chk("reset_ack1", 32'(ack1), 32'h0);
    chk("reset_rdata0", rdata0, 32'h0);
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_ram_addr", 32'(ram_addr), 32'h0);
    chk("reset_ram_wre", 32'(ram_wre), 32'h0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (!tbl[i].p) run_round(1'b1, 1'b0, tbl[i].we, 1'b0, tbl[i].a, 7'h0, tbl[i].d, 32'h0, 1'b0, 1'b0);
      else           run_round(1'b0, 1'b1, 1'b0, tbl[i].we, 7'h0, tbl[i].a, 32'h0, tbl[i].d, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_rdata", i), tbl[i].p ? rdata1 : rdata0, tbl[i].exp_rd);
    end

    // Reset in the middle of a write ACCESS.
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 32'hDEADBEEF;
    @(posedge clk); #1;
    chk("pre_rst_wre", 32'(ram_wre), 32'h1);
    chk("pre_rst_rdata0", rdata0, 32'h5A5A5A5A);
    ram_oe = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_wre", 32'(ram_wre), 32'h0);
    chk("rst_bus_released", ram_data, 32'h0);
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_ack1", 32'(ack1), 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    req0 = 1'b0; ram_oe = 1'b1;
    @(posedge clk); #1;
    chk("aborted_write", mem[7'h10], 32'h0);
    rst_n = 1'b1;
    ref_last = 1; ref_rd[0] = '0; ref_rd[1] = '0;
    @(posedge clk); #1;
    chk("post_rst_ack0", 32'(ack0), 32'h0);
    chk("post_rst_wre", 32'(ram_wre), 32'h0);

    // Contention: port 0 write wins the first tie, port 1 reads it back.
    run_round(1'b1, 1'b1, 1'b1, 1'b0, 7'h01, 7'h01, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0);
    chk("contention_rdata1", rdata1, 32'hAAAAAAAA);

    // Write then read from the other port with a bus-release probe in RESP.
    run_round(1'b1, 1'b1, 1'b1, 1'b0, 7'h7F, 7'h7F, 32'h12345678, 32'h0, 1'b1, 1'b0);
    chk("bus_rdata1", rdata1, 32'h12345678);

    hold(1'b1, 1'b1, 6);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b1, 2);

    // Client inputs change during ACCESS; latched values must be used.
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 7'h7F, 7'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("stable_rdata0", rdata0, 32'h12345678);
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 7'h0, 7'h02, 32'h0, 32'hC0FFEE11, 1'b0, 1'b1);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 7'h02, 7'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("stable_write_rdata0", rdata0, 32'hC0FFEE11);

    for (int i = 0; i < 40; i++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_round(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rnd_addr(), rnd_addr(), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk("wre_back_to_back", 32'(wre_viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
